// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_evt_pkg;

    localparam int N_DEF = 8;

    typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t;

    // Result of a round-robin search: found flag plus winning index.
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // First set bit of pend searching upward from rr, wrapping at n.
    function automatic pick_t rr_pick(input logic [31:0] pend, input logic [4:0] rr, input int n);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < n && !res.found) begin
                j = (int'(rr) + k) % n;
                if (pend[j]) begin
                    res.found = 1'b1;
                    res.idx   = 5'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_capture.sv
// Per-line edge detection, pending event latch and sticky overrun flags.
// Build option EDGE_EVT_ANY_EDGE_EN: when defined, both rising and falling
// transitions create events; otherwise only rising edges do.
module edge_capture #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic [N-1:0] in,
    input  logic [N-1:0] acc,
    input  logic [N-1:0] clr_overrun,
    output logic [N-1:0] pending,
    output logic [N-1:0] overrun
);

    logic [N-1:0] d_last;
    logic         primed;
    logic [N-1:0] edges;
    logic [N-1:0] ovr_set;

    // Edge detect; suppressed on the first cycle so lines high at reset release stay silent.
    always_comb begin
        edges = '0;
        if (primed) begin
`ifdef EDGE_EVT_ANY_EDGE_EN
            edges = in ^ d_last;
`else
            edges = in & ~d_last;
`endif
        end
        // An edge merging into a still-pending event, unless that event is accepted now.
        ovr_set = edges & pending & ~acc;
    end

    // History, pending and overrun state; a same-cycle accept and edge re-arms the line.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            d_last  <= '0;
            primed  <= 1'b0;
            pending <= '0;
            overrun <= '0;
        end else begin
            d_last  <= in;
            primed  <= 1'b1;
            pending <= (pending & ~acc) | edges;
            overrun <= ovr_set | (overrun & ~clr_overrun);
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures input edges as pending events and delivers them one at a time to a
// single consumer via valid/ready, with round-robin arbitration between lines.
// Build option EDGE_EVT_ANY_EDGE_EN (in edge_capture) enables both-edge events.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [N-1:0]     in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     overrun,
    input  logic [N-1:0]     clr_overrun
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] rr, rr_nxt, idx_nxt, rr_after;
    logic [N-1:0]     acc, cand;
    logic [4:0]       start;
    pick_t            pick;

    assign evt_valid = (state == ST_OFFER);

    // One-hot accept vector for the event taken by the consumer this cycle.
    always_comb begin
        acc = '0;
        if (evt_valid && evt_ready) acc[evt_idx] = 1'b1;
    end

    edge_capture #(.N(N)) u_capture (
        .clk         (clk),
        .aresetn     (aresetn),
        .in          (in),
        .acc         (acc),
        .clr_overrun (clr_overrun),
        .pending     (pending),
        .overrun     (overrun)
    );

    // Next-state logic: search registered pending (never this cycle's edges) from rr.
    always_comb begin
        state_nxt = state;
        idx_nxt   = evt_idx;
        rr_nxt    = rr;
        rr_after  = (evt_idx == IDX_W'(N - 1)) ? '0 : evt_idx + IDX_W'(1);
        cand      = pending;
        start     = 5'(rr);
        if (state == ST_OFFER) begin
            cand  = pending & ~acc;
            start = 5'(rr_after);
        end
        pick = rr_pick(32'(cand), start, N);
        case (state)
            ST_IDLE: begin
                if (pick.found) begin
                    state_nxt = ST_OFFER;
                    idx_nxt   = IDX_W'(pick.idx);
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    rr_nxt = rr_after;
                    if (pick.found) idx_nxt = IDX_W'(pick.idx);
                    else            state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbiter state, offered index and round-robin pointer.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            evt_idx <= '0;
            rr      <= '0;
        end else begin
            state   <= state_nxt;
            evt_idx <= idx_nxt;
            rr      <= rr_nxt;
        end
    end

endmodule
